// File: rtl/mux_scan.sv
// mux_scan: NCH-channel, WIDTH-bit registered multiplexer.
//   mode=0 : manual, the channel given by sel is forwarded when enabled.
//   mode=1 : automatic round-robin scan, DWELL cycles per enabled channel,
//            disabled channels are skipped, hold freezes the scan.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset
//   din   - packed channel data, channel k = din[k*WIDTH +: WIDTH]
//   en    - channel enable mask
//   mode  - 0 manual, 1 auto scan
//   sel   - manual channel select
//   hold  - auto mode: freeze pointer and dwell counter
//   y     - registered selected data (zero when not valid)
//   ch    - channel index that y belongs to
//   valid - y carries an enabled channel
//   wrap  - one-cycle pulse on the first cycle of a new sweep
module mux_scan #(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 4,
    parameter  int DWELL = 4,
    localparam int SW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] din,
    input  logic [NCH-1:0]       en,
    input  logic                 mode,
    input  logic [SW-1:0]        sel,
    input  logic                 hold,
    output logic [WIDTH-1:0]     y,
    output logic [SW-1:0]        ch,
    output logic                 valid,
    output logic                 wrap
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [SW-1:0]    r_p;
    logic [CW-1:0]    r_cnt;
    logic             r_pend;
    logic [WIDTH-1:0] r_y;
    logic [SW-1:0]    r_ch;
    logic             r_valid;
    logic             r_wrap;

    logic [WIDTH-1:0] w_din [NCH];
    logic [SW-1:0]    w_hi;
    logic             w_hi_found;
    logic [SW-1:0]    w_lo;
    logic [SW-1:0]    w_nxt;
    logic             w_sel_ok;
    logic [SW-1:0]    w_c;
    logic             w_v;
    logic [WIDTH-1:0] w_ynext;

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            w_din[i] = din[i*WIDTH +: WIDTH];
        end
    end

    // next_en(p): scanning from the top down, the last hit is the lowest
    // index; w_hi tracks the lowest enabled index strictly above p.
    always_comb begin
        w_hi       = '0;
        w_hi_found = 1'b0;
        w_lo       = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (en[NCH-1-i]) begin
                w_lo = SW'(NCH-1-i);
                if (SW'(NCH-1-i) > r_p) begin
                    w_hi       = SW'(NCH-1-i);
                    w_hi_found = 1'b1;
                end
            end
        end
        w_nxt = w_hi_found ? w_hi : w_lo;
    end

    // sel may exceed NCH-1 when NCH is not a power of two; such values
    // never match here, so they select nothing.
    always_comb begin
        w_sel_ok = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (sel == SW'(i) && en[i]) begin
                w_sel_ok = 1'b1;
            end
        end
    end

    always_comb begin
        if (!mode) begin
            w_c = sel;
            w_v = w_sel_ok;
        end else begin
            w_c = r_p;
            w_v = en[r_p];
        end
        w_ynext = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (w_v && w_c == SW'(i)) begin
                w_ynext = w_din[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p     <= '0;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_y     <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_ch    <= w_c;
            r_valid <= w_v;
            r_y     <= w_ynext;
            if (!mode) begin
                if (w_sel_ok) begin
                    r_p <= sel;
                end
                r_cnt  <= '0;
                r_pend <= 1'b0;
                r_wrap <= 1'b0;
            end else if (en == '0) begin
                r_pend <= 1'b0;
                r_wrap <= 1'b0;
            end else if (!en[r_p]) begin
                // Disabled pointer: skip ahead without flagging a sweep.
                r_p    <= w_nxt;
                r_cnt  <= '0;
                r_pend <= 1'b0;
                r_wrap <= r_pend;
            end else begin
                // r_pend is set on the advancing edge so that wrap rises
                // together with ch showing the new channel.
                r_wrap <= r_pend;
                r_pend <= 1'b0;
                if (!hold) begin
                    if (r_cnt == CW'(DWELL-1)) begin
                        r_p    <= w_nxt;
                        r_cnt  <= '0;
                        r_pend <= !w_hi_found;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            end
        end
    end

    assign y     = r_y;
    assign ch    = r_ch;
    assign valid = r_valid;
    assign wrap  = r_wrap;

endmodule

// File: tb/tb_mux_scan.sv
// tb_mux_scan: scoreboard bench for mux_scan (NCH=4, WIDTH=8, DWELL=2).
// A behavioural model predicts each edge's outputs when stimulus is
// applied; a checker process pops and compares them after the edge.
module tb_mux_scan;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int DWELL = 2;
    localparam int SW    = 2;

    typedef struct {
        logic [WIDTH-1:0] y;
        logic [SW-1:0]    ch;
        logic             valid;
        logic             wrap;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH*WIDTH-1:0] din;
    logic [NCH-1:0]       en;
    logic                 mode;
    logic [SW-1:0]        sel;
    logic                 hold;
    logic [WIDTH-1:0]     y;
    logic [SW-1:0]        ch;
    logic                 valid;
    logic                 wrap;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_p     = 0;
    int   m_cnt   = 0;
    bit   m_pend  = 1'b0;

    always #5 clk = ~clk;

    mux_scan #(.WIDTH(WIDTH), .NCH(NCH), .DWELL(DWELL)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .en    (en),
        .mode  (mode),
        .sel   (sel),
        .hold  (hold),
        .y     (y),
        .ch    (ch),
        .valid (valid),
        .wrap  (wrap)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: predicts outputs after the coming edge and advances its state.
    task automatic model_push();
        exp_t e;
        int   nx;
        bit   wraps;
        e = '{y: '0, ch: '0, valid: 1'b0, wrap: 1'b0};
        if (rst) begin
            m_p = 0; m_cnt = 0; m_pend = 1'b0;
        end else if (!mode) begin
            e.ch    = sel;
            e.valid = (int'(sel) < NCH) && en[sel];
            if (e.valid) begin
                e.y = din[int'(sel)*WIDTH +: WIDTH];
                m_p = int'(sel);
            end
            m_cnt = 0; m_pend = 1'b0;
        end else begin
            e.ch = SW'(m_p);
            nx = m_p;
            wraps = 1'b0;
            for (int k = 1; k <= NCH; k++) begin
                if (en[(m_p + k) % NCH]) begin
                    nx = (m_p + k) % NCH;
                    wraps = (nx <= m_p);
                    break;
                end
            end
            if (en == '0) begin
                m_pend = 1'b0;
            end else if (!en[m_p]) begin
                e.wrap = m_pend;
                m_p = nx; m_cnt = 0; m_pend = 1'b0;
            end else begin
                e.valid = 1'b1;
                e.y = din[m_p*WIDTH +: WIDTH];
                e.wrap = m_pend;
                m_pend = 1'b0;
                if (!hold) begin
                    if (m_cnt == DWELL-1) begin
                        m_p = nx; m_cnt = 0; m_pend = wraps;
                    end else begin
                        m_cnt++;
                    end
                end
            end
        end
        q.push_back(e);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            model_push();
            @(posedge clk);
            #2;
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("y",     32'(y),     32'(e.y));
            check("ch",    32'(ch),    32'(e.ch));
            check("valid", 32'(valid), 32'(e.valid));
            check("wrap",  32'(wrap),  32'(e.wrap));
        end
    end

    initial begin
        rst = 1'b1; mode = 1'b0; sel = '0; hold = 1'b0; en = 4'b1111;
        din = {8'h44, 8'h33, 8'h22, 8'h11};
        step(2);

        // Manual selection and enable masking
        rst = 1'b0; sel = 2'd2; step(1);
        en = 4'b1011; step(1);
        sel = 2'd3; step(1);

        // Full scan from channel 0
        en = 4'b1111; sel = 2'd0; step(1);
        mode = 1'b1; step(10);

        // Sparse mask, empty mask, single channel
        en = 4'b1010; step(8);
        en = 4'b0000; step(2);
        en = 4'b0100; step(6);

        // Hold while ch=2 with changing data, then release
        hold = 1'b1; en = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            din[2*WIDTH +: WIDTH] = 8'hA0 + 8'(k);
            step(1);
        end
        hold = 1'b0; step(4);

        // Reach channel 3 then reset mid-dwell
        for (int k = 0; k < 16 && m_p != 3; k++) step(1);
        check("reach_ch3", 32'(m_p), 32'd3);
        step(1);
        rst = 1'b1; step(1);
        rst = 1'b0; step(5);

        // Randomised traffic including mode switches and holds
        for (int k = 0; k < 300; k++) begin
            din  = $urandom;
            rst  = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            hold = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) en = 4'($urandom);
            sel  = 2'($urandom);
            step(1);
        end

        check("sb_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
